// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//  - cla_params_ok : elaboration-time legality check for WIDTH/BLOCK
//  - grp_gen       : group generate over the low n bits of a lookahead group
//  - grp_prop      : group propagate over the low n bits of a lookahead group
// The helpers work on MAX_BLOCK-wide vectors so one definition serves every
// BLOCK size; callers zero-extend their g/p terms.
package cla_pkg;

  localparam int MIN_BLOCK = 2;
  localparam int MAX_BLOCK = 16;

  function automatic bit cla_params_ok(int width, int block);
    return (block >= MIN_BLOCK) && (block <= MAX_BLOCK) &&
           (width >= block) && ((width % block) == 0);
  endfunction

  // G[n-1:0] = OR_j ( g[j] & p[j+1] & ... & p[n-1] ), j < n.
  // Unrolled at elaboration into a flat sum of products (no ripple chain).
  function automatic logic grp_gen(logic [MAX_BLOCK-1:0] g,
                                   logic [MAX_BLOCK-1:0] p, int n);
    logic r;
    logic t;
    r = 1'b0;
    for (int j = 0; j < MAX_BLOCK; j++) begin
      if (j < n) begin
        t = g[j];
        for (int m = j + 1; m < MAX_BLOCK; m++)
          if (m < n) t = t & p[m];
        r = r | t;
      end
    end
    return r;
  endfunction

  // P[n-1:0] = AND of p[0..n-1]; an empty group propagates (returns 1).
  function automatic logic grp_prop(logic [MAX_BLOCK-1:0] p, int n);
    logic r;
    r = 1'b1;
    for (int j = 0; j < MAX_BLOCK; j++)
      if (j < n) r = r & p[j];
    return r;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Handshake + operand/result bundle for cla_adder_pipe.
//  master : producer/consumer side (drives in_valid, a, b, sub, cin, out_ready)
//  slave  : adder side (drives in_ready, out_valid, sum, cout, ovf)
interface cla_adder_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group.
//  a, b     in   BLOCK  operand slices (b already conditioned for subtract)
//  c_in     in   1      carry into bit 0 of the group
//  s        out  BLOCK  sum slice
//  c_out    out  1      carry out of the group MSB
//  c_msb_in out  1      carry into the group MSB (for signed overflow)
// Every internal carry is its own flattened lookahead term from c_in.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [MAX_BLOCK-1:0] g;
  logic [MAX_BLOCK-1:0] p;
  logic [BLOCK:0]       c;

  assign g = MAX_BLOCK'(a & b);
  assign p = MAX_BLOCK'(a ^ b);

  // c[i] = G[i-1:0] | P[i-1:0] & c_in
  always_comb begin
    c = '0;
    for (int i = 0; i <= BLOCK; i++)
      c[i] = grp_gen(g, p, i) | (grp_prop(p, i) & c_in);
  end

  assign s        = a ^ b ^ c[BLOCK-1:0];
  assign c_out    = c[BLOCK];
  assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
//  clk, rst_n : clock, async active-low reset
//  io (slave) : in_valid/in_ready operand handshake (a, b, sub, cin),
//               out_valid/out_ready result handshake (sum, cout, ovf)
// WIDTH is split into NBLK groups of BLOCK bits; stage k resolves group k and
// registers it.  Operands travel down with their op (skew pipeline) and the
// already-resolved low sum slices are carried forward, so the last stage
// holds the complete result.  All stages advance together on in_ready.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_adder_pipe_if.slave io
);

  localparam int NBLK = WIDTH / BLOCK;

  if (!cla_params_ok(WIDTH, BLOCK)) begin : g_bad_params
    $error("cla_adder_pipe: illegal WIDTH=%0d / BLOCK=%0d", WIDTH, BLOCK);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // per-stage inputs (from the port for stage 0, else from stage k-1)
  logic [WIDTH-1:0] a_in [NBLK];
  logic [WIDTH-1:0] b_in [NBLK];
  logic [WIDTH-1:0] s_in [NBLK];
  logic             c_in [NBLK];

  // per-stage group results
  logic [BLOCK-1:0] gs [NBLK];
  logic             gc [NBLK];
  logic             gm [NBLK];

  // stage registers
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] s_q [NBLK];
  logic             c_q [NBLK];
  logic             msb_c_q;
  logic [NBLK-1:0]  vld_pipe;

  // subtract as A + ~B + 1
  assign b_eff = io.sub ? ~io.b : io.b;
  assign c_eff = io.sub | io.cin;

  assign io.in_ready  = ~io.out_valid | io.out_ready;
  assign adv          = io.in_ready;
  assign io.out_valid = vld_pipe[NBLK-1];
  assign io.sum       = s_q[NBLK-1];
  assign io.cout      = c_q[NBLK-1];
  assign io.ovf       = c_q[NBLK-1] ^ msb_c_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_in[0] = io.a;
      assign b_in[0] = b_eff;
      assign c_in[0] = c_eff;
      assign s_in[0] = '0;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a        (a_in[k][k*BLOCK +: BLOCK]),
      .b        (b_in[k][k*BLOCK +: BLOCK]),
      .c_in     (c_in[k]),
      .s        (gs[k]),
      .c_out    (gc[k]),
      .c_msb_in (gm[k])
    );
  end

  // Bubbles shift like ops: data regs may load junk, valid bit stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      msb_c_q  <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      vld_pipe[0] <= io.in_valid;
      for (int k = 1; k < NBLK; k++)
        vld_pipe[k] <= vld_pipe[k-1];
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]                    <= a_in[k];
        b_q[k]                    <= b_in[k];
        s_q[k]                    <= s_in[k];
        s_q[k][k*BLOCK +: BLOCK]  <= gs[k];
        c_q[k]                    <= gc[k];
      end
      msb_c_q <= gm[NBLK-1];
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: the driver pushes the model result at
// acceptance, an independent negedge monitor pops and compares on transfer.
module tb_cla_adder_pipe;

  localparam int W    = 16;
  localparam int B    = 8;
  localparam int NBLK = W / B;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic bp_mode = 1'b0;
  logic stall_prev = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  cla_adder_pipe_if #(.WIDTH(W)) bus ();

  cla_adder_pipe #(.WIDTH(W), .BLOCK(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // reference: plain integer arithmetic on the conditioned operands
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s, logic c);
    exp_t         r;
    logic [W-1:0] be;
    longint       ce, u, ss, smax, smin;
    be   = s ? ~b : b;
    ce   = (s || c) ? 1 : 0;
    u    = longint'(a) + longint'(be) + ce;
    ss   = longint'($signed(a)) + longint'($signed(be)) + ce;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (ss > smax) || (ss < smin);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // entered and left at posedge+1; waits (bounded) for acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    int t;
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(a, b, s, c));
        break;
      end
      t++;
      if (t > 100) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 100 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  // random back-pressure when enabled
  always begin
    @(posedge clk); #1;
    if (bp_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) stall_prev = 1'b0;
    else begin
      if (stall_prev) chk("stall_hold_valid", bus.out_valid, 1);
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (sb.size() != 0) chk("stall_hold_sum", bus.sum, sb[0].sum);
      end
      if (!bus.out_valid) chk("idle_in_ready", bus.in_ready, 1);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: got sum=%0h, expected no output", bus.sum);
        end else begin
          e = sb.pop_front();
          chk("sum",  bus.sum,  e.sum);
          chk("cout", bus.cout, e.cout);
          chk("ovf",  bus.ovf,  e.ovf);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, consec, t;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum",       bus.sum,       0);
    chk("rst_cout",      bus.cout,      0);
    chk("rst_ovf",       bus.ovf,       0);
    chk("rst_in_ready",  bus.in_ready,  1);
    rst_n = 1'b1;
    idle(1);
    bus.out_ready = 1'b1;

    // 1: single op, latency NBLK
    issue(16'd1, 16'd1, 1'b0, 1'b0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 20);
    chk("t1_latency", lat, NBLK);
    chk("t1_sum", bus.sum, 16'd2);
    idle(3);

    // 2,3: carry across groups, wrap, signed overflow
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0);
    issue(16'h1234, 16'h1234, 1'b1, 1'b0);
    issue(16'h0000, 16'h0001, 1'b1, 1'b1);
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    drain();

    // 4: back-to-back stream, results on consecutive cycles
    fork
      for (int k = 0; k < 15; k++) issue(W'(k), W'(k + 2), 1'b0, 1'b0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.out_valid && t < 50);
        consec = 1;
        repeat (14) begin
          @(negedge clk);
          if (bus.out_valid) consec++;
        end
        chk("t4_consecutive", consec, 15);
      end
    join
    drain();

    // 5: out_ready low for 3 cycles mid-stream
    fork
      for (int k = 0; k < 12; k++) issue(W'($urandom), W'($urandom), 1'b0, 1'($urandom));
      begin
        idle(5);
        bus.out_ready = 1'b0;
        idle(3);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // 6: reset with two ops in flight
    issue(16'h0011, 16'h0022, 1'b0, 1'b0);
    issue(16'h0033, 16'h0044, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_sum",       bus.sum,       0);
    chk("t6_cout",      bus.cout,      0);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(6);
    @(negedge clk);
    chk("t6_no_stale", bus.out_valid, 0);
    @(posedge clk); #1;

    // random with back-pressure
    bp_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    bp_mode = 1'b0;
    idle(1);
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
